// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes,
// ALU operation codes, controller states and datapath mux selects.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_EXEC_LUI,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } ctrl_state_e;

    // Which kind of ALU operation the controller wants; the decoder turns
    // the register/immediate classes into a concrete op from funct3/funct7.
    typedef enum logic [2:0] {
        CLS_ADD,
        CLS_SUB,
        CLS_PASS_B,
        CLS_R,
        CLS_I
    } alu_class_e;

    localparam logic [1:0] SRC_A_PC     = 2'd0;
    localparam logic [1:0] SRC_A_RS1    = 2'd1;
    localparam logic [1:0] SRC_A_OLDPC  = 2'd2;

    localparam logic [1:0] SRC_B_RS2    = 2'd0;
    localparam logic [1:0] SRC_B_IMM    = 2'd1;
    localparam logic [1:0] SRC_B_FOUR   = 2'd2;

    localparam logic [1:0] RES_ALUOUT   = 2'd0;
    localparam logic [1:0] RES_MEMDATA  = 2'd1;
    localparam logic [1:0] RES_ALU      = 2'd2;

    localparam logic       ADDR_PC      = 1'b0;
    localparam logic       ADDR_ALUOUT  = 1'b1;

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's requested ALU class plus funct3/funct7_b5 onto a
// concrete ALU operation. Purely combinational.
module alu_decoder
    import riscv_pkg::*;
(
    input  alu_class_e alu_class_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_b5_i,
    output alu_op_e    alu_ctrl_o
);

    // funct7_b5 selects SUB only for register ops; for immediates it only matters for SRAI
    always_comb begin
        alu_ctrl_o = ALU_ADD;
        case (alu_class_i)
            CLS_SUB:    alu_ctrl_o = ALU_SUB;
            CLS_PASS_B: alu_ctrl_o = ALU_PASS_B;
            CLS_R, CLS_I: begin
                case (funct3_i)
                    3'b000:  alu_ctrl_o = (alu_class_i == CLS_R && funct7_b5_i) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl_o = ALU_SLL;
                    3'b010:  alu_ctrl_o = ALU_SLT;
                    3'b011:  alu_ctrl_o = ALU_SLTU;
                    3'b100:  alu_ctrl_o = ALU_XOR;
                    3'b101:  alu_ctrl_o = funct7_b5_i ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl_o = ALU_OR;
                    default: alu_ctrl_o = ALU_AND;
                endcase
            end
            default:    alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core. Steady control levels are
// registered from the next state; strobes that depend on a same-cycle input
// (memory ready, ALU zero) are combined with the registered state.
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_ctrl,
    output logic [1:0] result_src,
    output logic       retire,
    output logic       trap
);

    localparam int              CntW    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

    ctrl_state_e     state_q, state_d;
    logic [CntW-1:0] tmoCnt_q, tmoCnt_d;
    logic            memReq_q, memWe_q, addrSrc_q;
    logic            regWrite_q, pcWrite_q, retire_q, trap_q;
    logic [1:0]      aluSrcA_q, aluSrcB_q, resultSrc_q;
    alu_op_e         aluCtrl_q, aluCtrl_d;
    alu_class_e      aluClass_d;
    logic            memDone, memWait, branchOk, branchTake;

    assign memDone    = memReq_q & mem_ready;
    assign memWait    = memReq_q & ~mem_ready;
    assign branchOk   = (funct3 == 3'b000) || (funct3 == 3'b001);
    assign branchTake = alu_zero ^ funct3[0];

    alu_decoder u_aluDecoder (
        .alu_class_i (aluClass_d),
        .funct3_i    (funct3),
        .funct7_b5_i (funct7_b5),
        .alu_ctrl_o  (aluCtrl_d)
    );

    // Next state, wait-cycle counter and the ALU class wanted in the next state
    always_comb begin
        state_d  = state_q;
        tmoCnt_d = memWait ? tmoCnt_q + 1'b1 : '0;
        case (state_q)
            S_FETCH:    if (memDone) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:               state_d = S_EXEC_R;
                    OP_I:               state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
                    OP_BRANCH:          state_d = S_BRANCH;
                    OP_JAL:             state_d = S_JAL;
                    OP_LUI:             state_d = S_EXEC_LUI;
                    default:            state_d = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I, S_EXEC_LUI: state_d = S_WB_ALU;
            S_MEM_ADDR: state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (memDone) state_d = S_WB_MEM;
            S_MEM_WR:   if (memDone) state_d = S_FETCH;
            S_WB_ALU, S_WB_MEM, S_JAL: state_d = S_FETCH;
            S_BRANCH:   state_d = branchOk ? S_FETCH : S_TRAP;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
        if (memWait && tmoCnt_q == CntLast) state_d = S_TRAP;

        case (state_d)
            S_EXEC_R:   aluClass_d = CLS_R;
            S_EXEC_I:   aluClass_d = CLS_I;
            S_EXEC_LUI: aluClass_d = CLS_PASS_B;
            S_BRANCH:   aluClass_d = CLS_SUB;
            default:    aluClass_d = CLS_ADD;
        endcase
    end

    // State register plus the control levels registered for the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            tmoCnt_q    <= '0;
            memReq_q    <= 1'b0;
            memWe_q     <= 1'b0;
            addrSrc_q   <= ADDR_PC;
            regWrite_q  <= 1'b0;
            pcWrite_q   <= 1'b0;
            retire_q    <= 1'b0;
            trap_q      <= 1'b0;
            aluSrcA_q   <= SRC_A_PC;
            aluSrcB_q   <= SRC_B_RS2;
            resultSrc_q <= RES_ALUOUT;
            aluCtrl_q   <= ALU_ADD;
        end else begin
            state_q     <= state_d;
            tmoCnt_q    <= tmoCnt_d;
            memReq_q    <= 1'b0;
            memWe_q     <= 1'b0;
            addrSrc_q   <= ADDR_PC;
            regWrite_q  <= 1'b0;
            pcWrite_q   <= 1'b0;
            retire_q    <= 1'b0;
            trap_q      <= (state_d == S_TRAP);
            aluSrcA_q   <= SRC_A_PC;
            aluSrcB_q   <= SRC_B_RS2;
            resultSrc_q <= RES_ALUOUT;
            aluCtrl_q   <= aluCtrl_d;
            case (state_d)
                S_FETCH: begin
                    memReq_q    <= 1'b1;
                    aluSrcB_q   <= SRC_B_FOUR;
                    resultSrc_q <= RES_ALU;
                end
                S_DECODE: begin
                    aluSrcA_q <= SRC_A_OLDPC;
                    aluSrcB_q <= SRC_B_IMM;
                end
                S_EXEC_R, S_BRANCH: begin
                    aluSrcA_q <= SRC_A_RS1;
                    aluSrcB_q <= SRC_B_RS2;
                end
                S_EXEC_I, S_MEM_ADDR: begin
                    aluSrcA_q <= SRC_A_RS1;
                    aluSrcB_q <= SRC_B_IMM;
                end
                S_EXEC_LUI: aluSrcB_q <= SRC_B_IMM;
                S_MEM_RD: begin
                    memReq_q  <= 1'b1;
                    addrSrc_q <= ADDR_ALUOUT;
                end
                S_MEM_WR: begin
                    memReq_q  <= 1'b1;
                    memWe_q   <= 1'b1;
                    addrSrc_q <= ADDR_ALUOUT;
                end
                S_WB_ALU: begin
                    regWrite_q <= 1'b1;
                    retire_q   <= 1'b1;
                end
                S_WB_MEM: begin
                    resultSrc_q <= RES_MEMDATA;
                    regWrite_q  <= 1'b1;
                    retire_q    <= 1'b1;
                end
                S_JAL: begin
                    aluSrcA_q   <= SRC_A_OLDPC;
                    aluSrcB_q   <= SRC_B_FOUR;
                    resultSrc_q <= RES_ALU;
                    regWrite_q  <= 1'b1;
                    pcWrite_q   <= 1'b1;
                    retire_q    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Strobes are suppressed while rst is high so a reset cycle commits nothing
    always_comb begin
        ir_write  = ~rst & (state_q == S_FETCH) & memDone;
        pc_write  = ~rst & (pcWrite_q
                          | ((state_q == S_FETCH) & memDone)
                          | ((state_q == S_BRANCH) & branchOk & branchTake));
        reg_write = ~rst & regWrite_q;
        retire    = ~rst & (retire_q
                          | ((state_q == S_MEM_WR) & memDone)
                          | ((state_q == S_BRANCH) & branchOk));
    end

    assign mem_req    = memReq_q;
    assign mem_we     = memWe_q;
    assign addr_src   = addrSrc_q;
    assign alu_src_a  = aluSrcA_q;
    assign alu_src_b  = aluSrcB_q;
    assign result_src = resultSrc_q;
    assign alu_ctrl   = aluCtrl_q;
    assign trap       = trap_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: a scoreboard of per-
// instruction expectations checked on every retire pulse, plus directed
// reset, trap, timeout and reset-during-store scenarios.
module tb_multicycle_controller;
    import riscv_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5, alu_zero, mem_ready;
    logic       mem_req, mem_we, addr_src, ir_write, pc_write, reg_write, retire, trap;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [3:0] alu_ctrl;

    multicycle_controller #(.MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_b5(funct7_b5),
        .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .addr_src(addr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .result_src(result_src), .retire(retire), .trap(trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    cycles;
        int    regW;
        int    pcW;
        int    dReq;
        int    op;
    } exp_t;

    localparam int NoOp = 15;

    exp_t expQ[$];
    exp_t popped;
    int   compared = 0;
    int   mismatched = 0;
    int   retireCount = 0;
    int   cyc, regW, pcW, dReq, opSeen;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Accumulate per-instruction activity and compare it against the scoreboard on each retire
    always @(negedge clk) begin
        if (rst) begin
            cyc = 0; regW = 0; pcW = 0; dReq = 0; opSeen = NoOp;
        end else begin
            cyc++;
            if (reg_write) regW++;
            if (pc_write) pcW++;
            if (mem_req && addr_src) dReq++;
            if (opSeen == NoOp && (alu_src_a == 2'd1 || (alu_src_a == 2'd0 && alu_src_b == 2'd1)))
                opSeen = int'(alu_ctrl);
            if (retire) begin
                retireCount++;
                checkOutput("retire_pending", int'(expQ.size() > 0), 1);
                if (expQ.size() > 0) begin
                    popped = expQ.pop_front();
                    checkOutput({popped.tag, "_cycles"}, cyc, popped.cycles);
                    checkOutput({popped.tag, "_regwrite"}, regW, popped.regW);
                    checkOutput({popped.tag, "_pcwrite"}, pcW, popped.pcW);
                    checkOutput({popped.tag, "_datareq"}, dReq, popped.dReq);
                    checkOutput({popped.tag, "_aluop"}, opSeen, popped.op);
                end
                cyc = 0; regW = 0; pcW = 0; dReq = 0; opSeen = NoOp;
            end
        end
    end

    task automatic doReset(input logic readyVal);
        rst = 1'b1;
        mem_ready = readyVal;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Run one instruction to retirement, stalling data accesses for dataWait cycles
    task automatic applyStimulus(input string tag, input logic [6:0] op, input logic [2:0] f3,
                                 input logic f7, input logic zero, input int dataWait,
                                 input int expCycles, input int expRegW, input int expPcW,
                                 input int expDReq, input int expOp);
        exp_t e;
        int   startCount;
        int   waitLeft;
        e.tag = tag; e.cycles = expCycles; e.regW = expRegW;
        e.pcW = expPcW; e.dReq = expDReq; e.op = expOp;
        expQ.push_back(e);
        opcode = op; funct3 = f3; funct7_b5 = f7; alu_zero = zero;
        startCount = retireCount;
        waitLeft = dataWait;
        for (int c = 0; c < 64 && retireCount == startCount; c++) begin
            @(posedge clk);
            #1;
            if (mem_req && addr_src && waitLeft > 0) begin
                mem_ready = 1'b0;
                waitLeft--;
            end else begin
                mem_ready = 1'b1;
            end
        end
        checkOutput({tag, "_retired"}, retireCount - startCount, 1);
        if (retireCount == startCount && expQ.size() > 0) void'(expQ.pop_back());
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int trapCyc, reqCyc;
        bit found;
        rst = 1'b1; opcode = OP_R; funct3 = 3'd0; funct7_b5 = 1'b0;
        alu_zero = 1'b0; mem_ready = 1'b1;

        // Reset values, then the first fetch encodings
        doReset(1'b1);
        @(negedge clk);
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_trap", trap, 0);
        checkOutput("rst_retire", retire, 0);
        checkOutput("rst_writes", {reg_write, pc_write, ir_write}, 0);
        checkOutput("rst_selects", {alu_src_a, alu_src_b, result_src}, 0);
        @(negedge clk);
        checkOutput("fetch_mem_req", mem_req, 1);
        checkOutput("fetch_addr_we", {addr_src, mem_we}, 0);
        checkOutput("fetch_alu_b", alu_src_b, 2);
        checkOutput("fetch_result_src", result_src, 2);
        checkOutput("fetch_alu_ctrl", alu_ctrl, int'(ALU_ADD));
        checkOutput("fetch_ir_pc_write", {ir_write, pc_write}, 3);

        // Instruction stream; the first one after reset pays one cycle raising mem_req
        doReset(1'b1);
        applyStimulus("add",      OP_R,      3'd0, 1'b0, 1'b0, 0, 5, 1, 1, 0, int'(ALU_ADD));
        applyStimulus("sub",      OP_R,      3'd0, 1'b1, 1'b0, 0, 4, 1, 1, 0, int'(ALU_SUB));
        applyStimulus("sltu",     OP_R,      3'd3, 1'b0, 1'b0, 0, 4, 1, 1, 0, int'(ALU_SLTU));
        applyStimulus("or",       OP_R,      3'd6, 1'b0, 1'b0, 0, 4, 1, 1, 0, int'(ALU_OR));
        applyStimulus("srai",     OP_I,      3'd5, 1'b1, 1'b0, 0, 4, 1, 1, 0, int'(ALU_SRA));
        applyStimulus("srli",     OP_I,      3'd5, 1'b0, 1'b0, 0, 4, 1, 1, 0, int'(ALU_SRL));
        applyStimulus("addi_f7",  OP_I,      3'd0, 1'b1, 1'b0, 0, 4, 1, 1, 0, int'(ALU_ADD));
        applyStimulus("lui",      OP_LUI,    3'd0, 1'b0, 1'b0, 0, 4, 1, 1, 0, int'(ALU_PASS_B));
        applyStimulus("lw_wait3", OP_LOAD,   3'd2, 1'b0, 1'b0, 3, 8, 1, 1, 4, int'(ALU_ADD));
        applyStimulus("lw",       OP_LOAD,   3'd2, 1'b0, 1'b0, 0, 5, 1, 1, 1, int'(ALU_ADD));
        applyStimulus("sw_wait1", OP_STORE,  3'd2, 1'b0, 1'b0, 1, 5, 0, 1, 2, int'(ALU_ADD));
        applyStimulus("sw",       OP_STORE,  3'd2, 1'b0, 1'b0, 0, 4, 0, 1, 1, int'(ALU_ADD));
        applyStimulus("beq_take", OP_BRANCH, 3'd0, 1'b0, 1'b1, 0, 3, 0, 2, 0, int'(ALU_SUB));
        applyStimulus("bne_skip", OP_BRANCH, 3'd1, 1'b0, 1'b1, 0, 3, 0, 1, 0, int'(ALU_SUB));
        applyStimulus("beq_skip", OP_BRANCH, 3'd0, 1'b0, 1'b0, 0, 3, 0, 1, 0, int'(ALU_SUB));
        applyStimulus("bne_take", OP_BRANCH, 3'd1, 1'b0, 1'b0, 0, 3, 0, 2, 0, int'(ALU_SUB));
        applyStimulus("jal",      OP_JAL,    3'd0, 1'b0, 1'b0, 0, 3, 1, 2, 0, NoOp);
        applyStimulus("and",      OP_R,      3'd7, 1'b0, 1'b0, 0, 4, 1, 1, 0, int'(ALU_AND));

        // Illegal opcode traps right after DECODE and stays trapped until reset
        doReset(1'b1);
        opcode = 7'b1111111;
        trapCyc = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (trap && trapCyc < 0) trapCyc = c;
        end
        checkOutput("illegal_trap_cycle", trapCyc, 4);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checkOutput("trap_hold_trap_req", {trap, mem_req}, 2);
        end
        doReset(1'b1);
        @(negedge clk);
        checkOutput("trap_cleared", trap, 0);
        @(negedge clk);
        checkOutput("refetch_after_trap", mem_req, 1);

        // Branch with an unsupported funct3 traps instead of retiring
        doReset(1'b1);
        opcode = OP_BRANCH; funct3 = 3'b100;
        trapCyc = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (trap && trapCyc < 0) trapCyc = c;
        end
        checkOutput("bad_branch_trap_cycle", trapCyc, 5);

        // Memory never ready: trap exactly MEM_TIMEOUT cycles after mem_req rises
        doReset(1'b0);
        opcode = OP_R; funct3 = 3'd0;
        reqCyc = -1; trapCyc = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (mem_req && reqCyc < 0) reqCyc = c;
            if (trap && trapCyc < 0) trapCyc = c;
        end
        checkOutput("timeout_req_cycle", reqCyc, 2);
        checkOutput("timeout_gap", trapCyc - reqCyc, 16);
        checkOutput("timeout_req_dropped", mem_req, 0);

        // Reset while a store would complete: no retire, request dropped, back to fetch
        doReset(1'b1);
        opcode = OP_STORE; funct3 = 3'd2;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk);
            #1;
            if (mem_req && mem_we) begin
                found = 1'b1;
                rst = 1'b1;
            end
            mem_ready = 1'b1;
        end
        checkOutput("memwr_reached", int'(found), 1);
        @(negedge clk);
        checkOutput("rst_blocks_retire", retire, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_drops_req", {mem_req, mem_we}, 0);
        checkOutput("rst_no_retire", retire, 0);
        @(negedge clk);
        checkOutput("rst_refetch", {mem_req, addr_src, mem_we}, 4);

        checkOutput("queue_drained", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
